// File: rtl/uart_poll_sched.sv
// RS-485 half-duplex poll scheduler: one request byte per period, then collects a
// fixed-length response into a small buffer, with turnaround guards and a timeout.
module uart_poll_sched #(
    parameter int unsigned RESP_LEN    = 14,
    parameter logic [7:0]  CMD_BYTE    = 8'hA5,
    parameter int unsigned PERIOD_CYC  = 80640,
    parameter int unsigned GUARD_CYC   = 16,
    parameter int unsigned TIMEOUT_CYC = 40000
) (
    input  logic        clk80,
    input  logic        rst,
    input  logic        enable,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic        UART0_dTX,
    output logic        UART0_dRX,
    output logic [3:0]  buf_addr,
    output logic [7:0]  buf_data,
    output logic        buf_we,
    output logic        frame_done,
    output logic        frame_timeout,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    localparam int unsigned PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GW = $clog2(GUARD_CYC + 2);

    typedef enum logic [2:0] {
        IDLE, DRV_ON, SEND, TX_WAIT, DRV_OFF, RECV, DONE, TOUT
    } state_t;

    state_t        state;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic [GW-1:0] gcnt;
    logic [3:0]    idx;

    logic       rx_good;
    logic       rx_bad;
    logic       last_byte;
    logic       tout_hit;
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    // A final byte arriving on the timeout cycle wins over the timeout.
    assign rx_good   = (state == RECV) && rx_valid && !rx_err;
    assign rx_bad    = (state == RECV) && rx_err;
    assign last_byte = rx_good && (idx == 4'(RESP_LEN - 1));
    assign tout_hit  = (state == RECV) && (tcnt == TW'(TIMEOUT_CYC - 1)) && !last_byte;
    assign err_inc   = 2'(rx_bad) + 2'(tout_hit);
    assign err_sum   = {1'b0, err_cnt} + {7'd0, err_inc};

    always_ff @(posedge clk80) begin
        if (rst) begin
            state         <= IDLE;
            pcnt          <= '0;
            tcnt          <= '0;
            gcnt          <= '0;
            idx           <= '0;
            tx_data       <= '0;
            tx_start      <= 1'b0;
            UART0_dTX     <= 1'b0;
            UART0_dRX     <= 1'b1;
            buf_addr      <= '0;
            buf_data      <= '0;
            buf_we        <= 1'b0;
            frame_done    <= 1'b0;
            frame_timeout <= 1'b0;
            frame_cnt     <= '0;
            err_cnt       <= '0;
        end else begin
            tx_start      <= 1'b0;
            buf_we        <= 1'b0;
            frame_done    <= 1'b0;
            frame_timeout <= 1'b0;
            err_cnt       <= err_sum[8] ? 8'hFF : err_sum[7:0];

            if (!enable || pcnt == PW'(PERIOD_CYC - 1)) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PW'(1);
            end

            case (state)
                IDLE: begin
                    if (enable && pcnt == '0) begin
                        state     <= DRV_ON;
                        gcnt      <= '0;
                        UART0_dTX <= 1'b1;
                        UART0_dRX <= 1'b1;
                    end
                end
                // Strobe is launched on the last guard cycle so it lands exactly GUARD_CYC after dTX.
                DRV_ON: begin
                    if (gcnt == GW'(GUARD_CYC - 1)) begin
                        state    <= SEND;
                        tx_start <= !tx_busy;
                        if (!tx_busy) begin
                            tx_data <= CMD_BYTE;
                        end
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                SEND: begin
                    if (tx_start) begin
                        state <= TX_WAIT;
                        gcnt  <= '0;
                    end else if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= CMD_BYTE;
                    end
                end
                TX_WAIT: begin
                    if (gcnt == '0) begin
                        gcnt <= GW'(1);
                    end else if (!tx_busy) begin
                        state     <= DRV_OFF;
                        gcnt      <= GW'(1);
                        UART0_dTX <= 1'b0;
                    end
                end
                // The cycle that saw tx_busy fall counts as the first turnaround cycle.
                DRV_OFF: begin
                    if (gcnt >= GW'(GUARD_CYC - 1)) begin
                        state     <= RECV;
                        idx       <= '0;
                        tcnt      <= '0;
                        UART0_dRX <= 1'b0;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                RECV: begin
                    tcnt <= tcnt + TW'(1);
                    if (rx_good) begin
                        buf_we   <= 1'b1;
                        buf_addr <= idx;
                        buf_data <= rx_data;
                        idx      <= idx + 4'd1;
                    end
                    if (last_byte) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        UART0_dRX  <= 1'b1;
                    end else if (tout_hit) begin
                        state         <= TOUT;
                        frame_timeout <= 1'b1;
                        UART0_dRX     <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                TOUT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_poll_sched.sv
// Scoreboard bench for uart_poll_sched: stimulus queues expected buffer writes and
// frame pulses; a negedge monitor pops and compares them as the DUT produces them.
module tb_uart_poll_sched;

    localparam int unsigned GUARD  = 4;
    localparam int unsigned TOUTC  = 1500;
    localparam int unsigned PERIOD = 2000;
    localparam int unsigned NRESP  = 14;
    localparam int unsigned TXLEN  = 10;

    logic        clk80 = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        tx_busy = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        UART0_dTX;
    logic        UART0_dRX;
    logic [3:0]  buf_addr;
    logic [7:0]  buf_data;
    logic        buf_we;
    logic        frame_done;
    logic        frame_timeout;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_idx = 0;
    logic [11:0] exp_wr[$];
    logic [7:0]  exp_ev[$];
    int wr_seen = 0, tx_seen = 0, recv_seen = 0, tout_seen = 0;
    int t_start = 0, t_recv = 0, t_tout = 0, t_txs = 0, t_busy_fall = 0, f1_start = 0;
    logic mon_on = 1'b0, dtx_q = 1'b0, drx_q = 1'b1;

    uart_poll_sched #(
        .RESP_LEN(NRESP), .CMD_BYTE(8'hA5), .PERIOD_CYC(PERIOD),
        .GUARD_CYC(GUARD), .TIMEOUT_CYC(TOUTC)
    ) dut (
        .clk80(clk80), .rst(rst), .enable(enable),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .UART0_dTX(UART0_dTX), .UART0_dRX(UART0_dRX),
        .buf_addr(buf_addr), .buf_data(buf_data), .buf_we(buf_we),
        .frame_done(frame_done), .frame_timeout(frame_timeout),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    initial forever #5 clk80 = ~clk80;
    always @(posedge clk80) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_ev(input logic [7:0] code);
        logic [7:0] want;
        checks++;
        if (exp_ev.size() == 0) begin
            errors++;
            $display("FAIL event: unexpected pulse %c at cycle %0d, none required", code, cyc);
        end else begin
            want = exp_ev.pop_front();
            if (want != code) begin
                errors++;
                $display("FAIL event: got %c, required %c", code, want);
            end
        end
    endtask

    function automatic logic [63:0] rst_vec();
        return {14'd0, tx_start, buf_we, frame_done, frame_timeout, UART0_dTX, UART0_dRX,
                tx_data, buf_addr, buf_data, frame_cnt, err_cnt};
    endfunction

    // Monitor: scoreboard pops, timestamps of direction/strobe edges, bus-contention watch.
    initial forever begin
        @(negedge clk80);
        if (mon_on) begin
            if (buf_we) begin
                wr_seen++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected addr=%0d data=%0h", buf_addr, buf_data);
                end else begin
                    logic [11:0] w;
                    w = exp_wr.pop_front();
                    if ({buf_addr, buf_data} != w) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%0h, required addr=%0d data=%0h",
                                 buf_addr, buf_data, w[11:8], w[7:0]);
                    end
                end
            end
            if (frame_done) chk_ev("D");
            if (frame_timeout) begin
                t_tout = cyc;
                tout_seen++;
                chk_ev("T");
            end
            if (tx_start) begin
                tx_seen++;
                t_txs = cyc;
                check("tx_data_on_start", 64'(tx_data), 64'h A5);
            end
            if (UART0_dTX && !dtx_q) t_start = cyc;
            if (!UART0_dRX && drx_q) begin
                t_recv = cyc;
                recv_seen++;
            end
            if (UART0_dTX && !UART0_dRX) begin
                checks++;
                errors++;
                $display("FAIL direction: dTX=1 with dRX=0 at cycle %0d, required never", cyc);
            end
            dtx_q = UART0_dTX;
            drx_q = UART0_dRX;
        end
    end

    // Transmitter model: busy for TXLEN cycles starting the cycle after the strobe.
    initial forever begin
        @(negedge clk80);
        if (tx_start === 1'b1) begin
            @(posedge clk80);
            #1 tx_busy = 1'b1;
            repeat (TXLEN) @(posedge clk80);
            #1 tx_busy = 1'b0;
            t_busy_fall = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        exp_wr.push_back({4'(exp_idx), b});
        exp_idx++;
        if (exp_idx == int'(NRESP)) exp_ev.push_back("D");
        @(posedge clk80);
        #1 rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk80);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_err();
        @(posedge clk80);
        #1 rx_err = 1'b1;
        @(posedge clk80);
        #1 rx_err = 1'b0;
    endtask

    task automatic wait_recv(input int bound, input string name);
        int n0;
        int k;
        n0 = recv_seen;
        k = 0;
        while (recv_seen == n0 && k < bound) begin
            @(posedge clk80);
            #1 k++;
        end
        check(name, 64'(recv_seen != n0), 64'd1);
        exp_idx = 0;
    endtask

    task automatic drain(input int bound, input string name);
        int k;
        k = 0;
        while ((exp_wr.size() != 0 || exp_ev.size() != 0) && k < bound) begin
            @(posedge clk80);
            #1 k++;
        end
        check(name, 64'(exp_wr.size() + exp_ev.size()), 64'd0);
        exp_wr.delete();
        exp_ev.delete();
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk80);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk80);
        #1 check("reset_values", rst_vec(), {14'd0, 6'b000001, 44'd0});
        rst = 1'b0;
        mon_on = 1'b1;

        // Stray byte while idle must not reach the buffer.
        @(posedge clk80);
        #1 rx_data = 8'h77;
        rx_valid = 1'b1;
        @(posedge clk80);
        #1 rx_valid = 1'b0;
        repeat (4) @(posedge clk80);
        #1 check("stray_rx_no_write", 64'(wr_seen), 64'd0);

        // Nominal frame.
        enable = 1'b1;
        wait_recv(100, "f1_recv_entry");
        f1_start = t_start;
        check("dtx_to_txstart", 64'(t_txs - t_start), 64'(GUARD));
        check("busy_fall_to_drx", 64'(t_recv - t_busy_fall), 64'(GUARD));
        for (int i = 0; i < int'(NRESP); i++) send_byte(8'(i * 5));
        drain(50, "f1_drain");
        check("f1_frame_cnt", 64'(frame_cnt), 64'd1);
        check("f1_err_cnt", 64'(err_cnt), 64'd0);
        check("f1_tx_count", 64'(tx_seen), 64'd1);

        // Short response times out.
        wait_recv(2600, "f2_recv_entry");
        check("f2_on_schedule", 64'(t_start - f1_start), 64'(PERIOD));
        exp_ev.push_back("T");
        for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i));
        drain(1600, "f2_drain");
        check("f2_timeout_latency", 64'(t_tout - t_recv), 64'(TOUTC));
        check("f2_err_cnt", 64'(err_cnt), 64'd1);
        check("f2_frame_cnt", 64'(frame_cnt), 64'd1);

        // Framing error on the third byte, then 14 good bytes.
        wait_recv(2600, "f3_recv_entry");
        check("f3_on_schedule", 64'(t_start - f1_start), 64'(2 * PERIOD));
        for (int i = 0; i < 2; i++) send_byte(8'(8'h10 + i));
        send_err();
        for (int i = 2; i < int'(NRESP); i++) send_byte(8'(8'h10 + i));
        drain(50, "f3_drain");
        check("f3_err_cnt", 64'(err_cnt), 64'd2);
        check("f3_frame_cnt", 64'(frame_cnt), 64'd2);

        // Framing error on the timeout cycle counts twice.
        wait_recv(2600, "f4_recv_entry");
        exp_ev.push_back("T");
        wait_until(t_recv + int'(TOUTC) - 1);
        rx_err = 1'b1;
        @(posedge clk80);
        #1 rx_err = 1'b0;
        drain(50, "f4_drain");
        check("f4_err_cnt", 64'(err_cnt), 64'd4);
        check("f4_frame_cnt", 64'(frame_cnt), 64'd2);

        // Final byte on the timeout cycle completes the frame instead.
        wait_recv(2600, "f5_recv_entry");
        for (int i = 0; i < int'(NRESP) - 1; i++) send_byte(8'(8'h80 + i));
        wait_until(t_recv + int'(TOUTC) - 2);
        send_byte(8'h8D);
        drain(50, "f5_drain");
        check("f5_frame_cnt", 64'(frame_cnt), 64'd3);
        check("f5_err_cnt", 64'(err_cnt), 64'd4);
        check("f5_timeouts", 64'(tout_seen), 64'd2);

        // Reset after 7 bytes aborts silently; next frame restarts at address 0.
        wait_recv(2600, "f6_recv_entry");
        for (int i = 0; i < 7; i++) send_byte(8'(8'h20 + i));
        drain(10, "f6_drain");
        rst = 1'b1;
        @(posedge clk80);
        #1 check("midframe_reset_values", rst_vec(), {14'd0, 6'b000001, 44'd0});
        rst = 1'b0;
        wait_recv(100, "f7_recv_entry");
        for (int i = 0; i < int'(NRESP); i++) send_byte(8'(8'hC0 + i));
        drain(50, "f7_drain");
        check("f7_frame_cnt", 64'(frame_cnt), 64'd1);
        check("f7_err_cnt", 64'(err_cnt), 64'd0);
        check("total_writes", 64'(wr_seen), 64'd73);
        check("total_tx_starts", 64'(tx_seen), 64'd7);

        repeat (5) @(posedge clk80);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
